// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM state encoding,
// frame-shape constants and the baud divider helper.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  // Truncating division; callers must keep the result >= 2.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Byte-write side and status/serial outputs of the buffered UART transmitter.
// master = command/echo logic, slave = the transmitter.
interface uart_tx_buffered_if #(
    parameter int FIFO_DEPTH = 16
);

    logic [7:0]                    wr_data;
    logic                          wr_en;
    logic                          full;
    logic                          empty;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          overflow;
    logic                          uart_tx_out;
    logic                          tx_busy;

    modport master (
        output wr_data, wr_en,
        input  full, empty, fifo_count, overflow, uart_tx_out, tx_busy
    );

    modport slave (
        input  wr_data, wr_en,
        output full, empty, fifo_count, overflow, uart_tx_out, tx_busy
    );

endinterface

// File: rtl/uart_byte_fifo.sv
// Single-clock byte FIFO with first-word-fall-through read data.
// Writes while full and reads while empty are ignored.
module uart_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    input  logic                     rd_en,
    output logic [7:0]               rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_ok;
    logic          rd_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; occupancy alone decides
    // validity, and leaving it unreset lets it map onto RAM.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// UART 8N1 transmitter fed from an internal byte FIFO; queued bytes are sent
// back-to-back, LSB first, with the line driven from a register.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    uart_tx_buffered_if.slave  bus
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int CW           = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_t        state_q, state_d;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_out_q, line_d;
    logic             overflow_q;
    logic             bit_done;
    logic             pop;
    logic [7:0]       head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;

    uart_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (bus.wr_en),
        .wr_data (bus.wr_data),
        .rd_en   (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign bit_done = (baud_cnt_q == BAUD_LAST);

    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q + 1'b1;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        pop        = 1'b0;
        line_d     = 1'b1;

        case (state_q)
            IDLE: begin
                baud_cnt_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    state_d = START;
                end
            end
            START: begin
                line_d = 1'b0;
                if (bit_done) begin
                    baud_cnt_d = '0;
                    bit_idx_d  = '0;
                    state_d    = DATA;
                end
            end
            DATA: begin
                line_d = shift_q[0];
                if (bit_done) begin
                    baud_cnt_d = '0;
                    if (bit_idx_q == 3'(DATA_BITS - 1)) begin
                        bit_idx_d = '0;
                        state_d   = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                    end
                end
            end
            STOP: begin
                if (bit_done) begin
                    baud_cnt_d = '0;
                    if (bit_idx_q != 3'(STOP_BITS - 1)) begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end else if (!fifo_empty) begin
                        // Chain straight into the next start bit: no idle gap.
                        pop       = 1'b1;
                        shift_d   = head;
                        bit_idx_d = '0;
                        state_d   = START;
                    end else begin
                        bit_idx_d = '0;
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The line register follows the state one cycle later, so a reset on any
    // edge also returns the line high on that same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_out_q   <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_out_q   <= line_d;
            overflow_q <= overflow_q | (bus.wr_en & fifo_full);
        end
    end

    assign bus.full        = fifo_full;
    assign bus.empty       = fifo_empty;
    assign bus.fifo_count  = fifo_count;
    assign bus.overflow    = overflow_q;
    assign bus.uart_tx_out = tx_out_q;
    assign bus.tx_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench: a line decoder turns the serial output back into bytes
// and compares them with the bytes the bench queued; timing is checked by cycle.
module tb_uart_tx_buffered;

    localparam int CLK_FREQ   = 1_000_000;
    localparam int BAUD_RATE  = 100_000;
    localparam int FIFO_DEPTH = 16;
    localparam int CPB        = CLK_FREQ / BAUD_RATE;
    localparam int FRAME      = 10 * CPB;

    typedef struct {
        logic [7:0] data;
        int         start;
        logic       stop_ok;
    } frame_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    frame_t     rx_q[$];
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_buffered_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus ();

    uart_tx_buffered #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD_RATE  (BAUD_RATE),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b);
        bus.wr_data = b;
        bus.wr_en   = 1'b1;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // Line level of bit slot j of an 8N1 frame carrying d.
    function automatic logic frame_bit(input logic [7:0] d, input int j);
        if (j == 0) return 1'b0;
        if (j <= 8) return d[j-1];
        return 1'b1;
    endfunction

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!(bus.empty && !bus.tx_busy) && n < 5000) begin
            tick();
            n++;
        end
        check(tag, n < 5000, 1'b1);
        repeat (5) tick();
    endtask

    task automatic compare_frames(input string tag);
        frame_t     fr;
        logic [7:0] e;
        wait_idle({tag, "_idle"});
        check({tag, "_nframes"}, rx_q.size(), exp_q.size());
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            fr = rx_q.pop_front();
            e  = exp_q.pop_front();
            check({tag, "_byte"}, fr.data, e);
            check({tag, "_stop"}, fr.stop_ok, 1'b1);
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    // Line decoder: start found on its first low cycle, bits sampled mid-cell.
    initial begin : monitor
        frame_t fr;
        forever begin
            @(negedge clk);
            if (rst_n && bus.uart_tx_out === 1'b0) begin
                fr.start = cyc;
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    fr.data[i] = bus.uart_tx_out;
                end
                repeat (CPB) @(negedge clk);
                fr.stop_ok = bus.uart_tx_out;
                rx_q.push_back(fr);
            end
        end
    end

    initial begin : stimulus
        int         errs;
        int         errs2;
        int         cnt;
        int         peak;
        int         k;
        logic       exp_line;
        logic [7:0] b;
        logic [7:0] first;

        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        repeat (2) tick();
        rst_n = 1'b1;

        check("rst_empty", bus.empty, 1'b1);
        check("rst_full", bus.full, 1'b0);
        check("rst_overflow", bus.overflow, 1'b0);
        check("rst_line", bus.uart_tx_out, 1'b1);
        check("rst_busy", bus.tx_busy, 1'b0);
        check("rst_count", bus.fifo_count, 0);

        // Idle: nothing may move for 1000 cycles.
        errs = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (bus.uart_tx_out !== 1'b1 || bus.tx_busy !== 1'b0) errs++;
        end
        check("idle_quiet", errs, 0);

        // Single byte: exact waveform from the write edge E.
        write_byte(8'h55);
        exp_q.push_back(8'h55);
        errs = 0; errs2 = 0; cnt = 0;
        for (int i = 1; i <= 110; i++) begin
            tick();
            exp_line = (i >= 2 && i < 2 + FRAME) ? frame_bit(8'h55, (i - 2) / CPB) : 1'b1;
            if (bus.uart_tx_out !== exp_line) errs++;
            if (bus.tx_busy !== (i <= FRAME)) errs2++;
            if (bus.tx_busy === 1'b1) cnt++;
            if (i == 2) check("single_empty_e2", bus.empty, 1'b1);
        end
        check("single_line_wave", errs, 0);
        check("single_busy_wave", errs2, 0);
        check("single_busy_len", cnt, FRAME);
        compare_frames("single");

        // Burst of three on consecutive edges.
        peak = 0;
        bus.wr_en = 1'b1;
        bus.wr_data = 8'hA5; tick(); if (bus.fifo_count > peak) peak = bus.fifo_count;
        bus.wr_data = 8'h00; tick(); if (bus.fifo_count > peak) peak = bus.fifo_count;
        bus.wr_data = 8'hFF; tick(); if (bus.fifo_count > peak) peak = bus.fifo_count;
        bus.wr_en = 1'b0;
        exp_q.push_back(8'hA5); exp_q.push_back(8'h00); exp_q.push_back(8'hFF);
        for (int i = 0; i < 3 * FRAME + 20; i++) begin
            tick();
            if (bus.fifo_count > peak) peak = bus.fifo_count;
        end
        check("burst_peak", peak, 2);
        wait_idle("burst_idle0");
        if (rx_q.size() >= 3) begin
            check("burst_gap01", rx_q[1].start - rx_q[0].start, FRAME);
            check("burst_gap12", rx_q[2].start - rx_q[1].start, FRAME);
        end
        compare_frames("burst");

        // Overflow: 17 writes while a frame is in flight.
        write_byte(8'h3C);
        exp_q.push_back(8'h3C);
        repeat (3) tick();
        for (int i = 0; i <= 16; i++) begin
            bus.wr_data = 8'(i);
            bus.wr_en = 1'b1;
            tick();
            if (i == 15) begin
                check("ovf_full", bus.full, 1'b1);
                check("ovf_clear_before", bus.overflow, 1'b0);
                check("ovf_count16", bus.fifo_count, FIFO_DEPTH);
            end
            if (i < 16) exp_q.push_back(8'(i));
        end
        bus.wr_en = 1'b0;
        check("ovf_set", bus.overflow, 1'b1);
        check("ovf_count_after", bus.fifo_count, FIFO_DEPTH);
        wait_idle("ovf_drain");
        check("ovf_sticky", bus.overflow, 1'b1);
        compare_frames("ovf");
        do_reset();
        check("ovf_reset_clear", bus.overflow, 1'b0);

        // Full FIFO with a write on the exact edge STOP pops.
        b = 8'($urandom);
        write_byte(b);
        exp_q.push_back(b);
        k = 0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            b = 8'($urandom);
            write_byte(b);
            exp_q.push_back(b);
            k++;
        end
        check("fp_full", bus.full, 1'b1);
        while (k < FRAME) begin
            tick();
            k++;
        end
        bus.wr_data = 8'h77;
        bus.wr_en = 1'b1;
        tick();
        bus.wr_en = 1'b0;
        check("fp_overflow", bus.overflow, 1'b1);
        check("fp_count", bus.fifo_count, FIFO_DEPTH - 1);
        check("fp_busy", bus.tx_busy, 1'b1);
        compare_frames("fp");
        do_reset();

        // Reset during DATA bit 3 with four bytes queued.
        first = 8'($urandom);
        write_byte(first);
        for (int i = 0; i < 4; i++) write_byte(8'($urandom));
        k = 4;
        check("mf_queued", bus.fifo_count, 4);
        while (k < 45) begin
            tick();
            k++;
        end
        check("mf_bit3", bus.uart_tx_out, first[3]);
        do_reset();
        check("mf_line", bus.uart_tx_out, 1'b1);
        check("mf_busy", bus.tx_busy, 1'b0);
        check("mf_empty", bus.empty, 1'b1);
        check("mf_count", bus.fifo_count, 0);
        check("mf_overflow", bus.overflow, 1'b0);
        errs = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            tick();
            if (bus.uart_tx_out !== 1'b1 || bus.tx_busy !== 1'b0) errs++;
        end
        check("mf_no_more_frames", errs, 0);
        rx_q.delete();
        exp_q.delete();

        // Random rounds of writes with random gaps, never allowed to overflow.
        for (int r = 0; r < 10; r++) begin
            int n = 0;
            while (bus.fifo_count > 10 && n < 3000) begin
                tick();
                n++;
            end
            check("rnd_guard", n < 3000, 1'b1);
            k = $urandom_range(1, 5);
            for (int j = 0; j < k; j++) begin
                b = 8'($urandom);
                write_byte(b);
                exp_q.push_back(b);
                repeat ($urandom_range(0, 3)) tick();
            end
            repeat ($urandom_range(0, 200)) tick();
        end
        check("rnd_no_overflow", bus.overflow, 1'b0);
        compare_frames("rnd");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
- UART 8N1 transmitter with an internal byte FIFO, so that bytes received by the UART receiver can be echoed or replied to without being dropped while a frame is in flight.
- Sits between the command/echo logic in the board top level and the GPIO TX pin.
- Accepts byte writes at clock rate and serialises the bytes LSB-first at the configured baud rate, back-to-back, with no idle gap.

Parameters:
- CLK_FREQ, 50000000: input clock frequency in Hz.
- BAUD_RATE, 115200: line rate in bits/s. Derived localparam CLKS_PER_BIT = CLK_FREQ/BAUD_RATE, truncating division (434 at defaults); must be ≥ 2.
- FIFO_DEPTH, 16: byte storage; must be a power of 2, ≥ 2.

Ports:
- clk  in  1  system clock (CLOCK_50 at top).
- rst_n  in  1  reset; synchronous, active-low.
- wr_data  in  8  byte to enqueue.
- wr_en  in  1  enqueue strobe; sampled each clk edge.
- full  out  1  FIFO holds FIFO_DEPTH bytes.
- empty  out  1  FIFO holds 0 bytes.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- overflow  out  1  sticky: a write was attempted while full.
- uart_tx_out  out  1  serial line; idle high; registered.
- tx_busy  out  1  high while a frame is being shifted (state != IDLE).

Behaviour:
- Reset (rst_n low at a clk edge):
  - FSM goes to IDLE; FIFO pointers and fifo_count go to 0.
  - Outputs after reset: empty=1, full=0, overflow=0, uart_tx_out=1, tx_busy=0.
  - Reset mid-frame aborts the frame: the line returns high on that edge and the partial frame is not resumed.
- FIFO write: when wr_en && !full, wr_data is stored and fifo_count increments on the same edge.
  - wr_en while full: the byte is dropped, overflow is set, and overflow stays set until reset.
  - full is evaluated from the pre-edge count. A write on a full FIFO is dropped even if the FSM pops on the same edge.
- Simultaneous push and pop on a non-full FIFO: count is unchanged and both operations take effect.
- No bypass: a write to an empty FIFO is popped on the following edge at the earliest.
- FIFO pop: performed only by the FSM, only when !empty. The head byte is loaded into the 8-bit shift register on the same edge.
- FSM states:
  - IDLE: uart_tx_out=1. If !empty: pop, go to START, drive uart_tx_out=0.
  - START: hold 0 for CLKS_PER_BIT cycles, then go to DATA and drive bit 0.
  - DATA: each bit is held CLKS_PER_BIT cycles, LSB first. A 3-bit index counts 0..7; after bit 7 go to STOP and drive 1.
  - STOP: hold 1 for CLKS_PER_BIT cycles. At the end, if !empty: pop and go directly to START. Otherwise go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and is cleared on every state or bit transition. Counter width is $clog2(CLKS_PER_BIT).
- Timing:
  - Latency: with wr_en sampled at edge E into an empty FIFO while IDLE, uart_tx_out falls at edge E+2.
  - Each frame is exactly 10*CLKS_PER_BIT cycles.
  - Consecutive queued frames have zero idle cycles between the stop bit and the next start bit.
- tx_busy is combinational from the state register and has no glitch relative to uart_tx_out transitions.
- Control signals only ever leave IDLE on a non-empty FIFO. No other inputs affect the FSM.

Decomposition:
- Shared package uart_pkg:
  - FSM state encoding (IDLE, START, DATA, STOP).
  - Function clks_per_bit(clk_freq, baud).
  - Constants DATA_BITS=8, STOP_BITS=1.
- One sub-module, uart_byte_fifo:
  - Synchronous single-clock FIFO, parameterised by depth.
  - Ports: clk, rst_n, wr_en, wr_data, rd_en, rd_data, full, empty, count.
  - rd_data is first-word-fall-through (head visible when !empty).
- The top of this block holds the FSM, baud counter, shift register and overflow flag.

Test Plan:
- Use CLK_FREQ=1000000 and BAUD_RATE=100000 (CLKS_PER_BIT=10) for all scenarios.
- Single byte: write 0x55 at edge E.
  - Line is low at E+2, then bits 1,0,1,0,1,0,1,0 each for 10 cycles, then high.
  - tx_busy is high for exactly 100 cycles; empty is high again at E+2.
- Burst: write 0xA5, 0x00, 0xFF on three consecutive edges.
  - Three frames are emitted back-to-back over 300 cycles with no extra high cycles between stop and start.
  - fifo_count peaks at 2.
- Overflow: while the first frame is in progress, write 17 bytes 0x00..0x10.
  - full asserts and overflow is set on the dropped 0x10 write and stays 1.
  - The serial output carries exactly 0x00..0x0F in order.
- Full with simultaneous pop: fill the FIFO, then assert wr_en with 0x77 on the exact edge STOP pops.
  - 0x77 is dropped, overflow=1, count becomes FIFO_DEPTH-1.
- Reset mid-frame: assert rst_n low for 1 edge during DATA bit 3 with 4 bytes queued.
  - Next cycle: uart_tx_out=1, tx_busy=0, empty=1, fifo_count=0, overflow=0.
  - No further frames are emitted.
- Idle: no writes for 1000 cycles after reset.
  - uart_tx_out stays 1 and tx_busy stays 0 throughout.
